player_shot_pool: RTL

- Transmitter side of the player-bullet interface consumed by every enemy block's collision check.
- Owns a fixed pool of player bullets: spawns them from the player's muzzle on the fire key, advances them each frame and compensates for screen scroll.
- Retires each bullet when it leaves the screen or when collision logic reports that slot as a hit.
- Drives the five bullet coordinate pairs (bX/bY, b1X/b1Y … b4X/b4Y) fanned out to all enemies.

---
 rtl/player_shot_pool.sv | 122 ++++++++++++
 1 files changed

// File: rtl/player_shot_pool.sv
// player_shot_pool: five-slot player bullet pool with spawn, flight, scroll compensation and retirement
module player_shot_pool #(
    parameter int SPEED       = 6,
    parameter int COOLDOWN    = 8,
    parameter int SCROLL_STEP = 2,
    parameter int MUZZLE_DY   = 23,
    parameter int SCREEN_W    = 640,
    parameter int PARK        = 1023
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       play,
    input  logic       fire_key,
    input  logic       facing,
    input  logic       scroll,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    input  logic [9:0] playerW,
    input  logic [4:0] hit_mask,
    output logic [9:0] bX,
    output logic [9:0] bY,
    output logic [9:0] b1X,
    output logic [9:0] b1Y,
    output logic [9:0] b2X,
    output logic [9:0] b2Y,
    output logic [9:0] b3X,
    output logic [9:0] b3Y,
    output logic [9:0] b4X,
    output logic [9:0] b4Y,
    output logic [4:0] shot_live,
    output logic       fire_pulse
);
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam logic [9:0] PK = 10'(PARK);
    localparam logic [9:0] XMAX = 10'(SCREEN_W - 1);

    logic [9:0]    x_q [5];
    logic [9:0]    x_d [5];
    logic [9:0]    y_q [5];
    logic [9:0]    y_d [5];
    logic [11:0]   nx [5];
    logic [4:0]    live_q, live_d, dir_q, dir_d;
    logic [CW-1:0] cd_q, cd_d;
    logic          pulse_q, pulse_d;
    logic [10:0]   sum;
    logic [9:0]    sx, sy;
    logic [2:0]    tgt;
    logic          spawn;

    always_comb begin
        sum = {1'b0, playerX} + {1'b0, playerW};
        sx = facing ? ((sum > {1'b0, XMAX}) ? XMAX : sum[9:0]) : playerX;
        sy = (playerY < 10'(MUZZLE_DY)) ? 10'd0 : playerY - 10'(MUZZLE_DY);
        tgt = 3'd0;
        for (int i = 4; i >= 0; i--) tgt = live_q[i] ? tgt : 3'(i);
        // eligibility uses live flags from the start of the frame, so same-frame retirees wait
        spawn = play && fire_key && (cd_q == '0) && !(&live_q);
        x_d = x_q;
        y_d = y_q;
        live_d = live_q;
        dir_d = dir_q;
        cd_d = cd_q;
        pulse_d = spawn;
        for (int i = 0; i < 5; i++) begin
            nx[i] = {2'b00, x_q[i]} + (dir_q[i] ? 12'(SPEED) : -12'(SPEED))
                  - (scroll ? 12'(SCROLL_STEP) : 12'd0);
            if (play && live_q[i]) begin
                if (hit_mask[i] || nx[i][11] || nx[i] > {2'b00, XMAX}) begin
                    x_d[i] = PK;
                    y_d[i] = PK;
                    live_d[i] = 1'b0;
                end else begin
                    x_d[i] = nx[i][9:0];
                end
            end
        end
        if (spawn) begin
            x_d[tgt] = sx;
            y_d[tgt] = sy;
            live_d[tgt] = 1'b1;
            dir_d[tgt] = facing;
            cd_d = CW'(COOLDOWN - 1);
        end else if (play && cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 5; i++) begin
                x_q[i] <= PK;
                y_q[i] <= PK;
            end
            live_q  <= '0;
            dir_q   <= '0;
            cd_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            live_q  <= live_d;
            dir_q   <= dir_d;
            cd_q    <= cd_d;
            pulse_q <= pulse_d;
        end
    end

    assign bX = x_q[0];
    assign bY = y_q[0];
    assign b1X = x_q[1];
    assign b1Y = y_q[1];
    assign b2X = x_q[2];
    assign b2Y = y_q[2];
    assign b3X = x_q[3];
    assign b3Y = y_q[3];
    assign b4X = x_q[4];
    assign b4Y = y_q[4];
    assign shot_live = live_q;
    assign fire_pulse = pulse_q;
endmodule
